// File: rtl/palette_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : palette_ctrl
// Brief    : Palette RAM controller: CPU write queue, whole-palette fill
//            engine and CPU readback that yields to the display fetch.
// Revision : 1.0 - initial release
// ============================================================================
module palette_ctrl #(
    parameter int WR_FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        cpu_wr_req_i,
    output logic        cpu_wr_ready_o,
    input  logic [7:0]  cpu_wr_addr_i,
    input  logic [1:0]  cpu_wr_ben_i,
    input  logic [15:0] cpu_wr_data_i,

    input  logic        cpu_rd_req_i,
    input  logic [7:0]  cpu_rd_addr_i,
    output logic        cpu_rd_valid_o,
    output logic [15:0] cpu_rd_data_o,
    output logic        cpu_rd_busy_o,

    input  logic        fill_start_i,
    input  logic [15:0] fill_value_i,
    output logic        fill_busy_o,

    input  logic        disp_active_i,
    input  logic [7:0]  disp_addr_i,

    output logic        pal_wr_en_o,
    output logic [1:0]  pal_ben_o,
    output logic [7:0]  pal_wr_addr_o,
    output logic [15:0] pal_wr_data_o,

    output logic [7:0]  pal_rd_addr_o,
    input  logic [15:0] pal_rd_data_i
);

    localparam int AW = $clog2(WR_FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(WR_FIFO_DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t         state;
    logic [7:0]     fill_cnt;
    logic [15:0]    fill_val;

    // Queue entry layout: {ben[1:0], addr[7:0], data[15:0]}
    logic [25:0]    fifo_mem [WR_FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;

    logic           rd_pend;
    logic           rd_inflight;
    logic [7:0]     rd_addr;
    logic           rd_issue;

    assign fifo_full      = (count == FULL_COUNT);
    assign fifo_empty     = (count == '0);
    assign cpu_wr_ready_o = !fifo_full;
    assign push           = cpu_wr_req_i && !fifo_full;
    assign pop            = (state == IDLE) && !fifo_empty && !fill_start_i;
    assign cpu_rd_busy_o  = rd_pend;

    // The last popped write is still on the registered write port when the
    // queue reads empty; waiting for it to land keeps read-after-write exact.
    assign rd_issue = rd_pend && !rd_inflight && !disp_active_i && fifo_empty
                      && (state == IDLE) && !pal_wr_en_o;

    always_comb begin
        pal_rd_addr_o = 8'h00;
        if (disp_active_i) begin
            pal_rd_addr_o = disp_addr_i;
        end else if (rd_issue) begin
            pal_rd_addr_o = rd_addr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cpu_wr_ben_i, cpu_wr_addr_i, cpu_wr_data_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            fill_cnt      <= 8'h00;
            fill_val      <= 16'h0000;
            fill_busy_o   <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            pal_wr_en_o   <= 1'b0;
            pal_ben_o     <= 2'b00;
            pal_wr_addr_o <= 8'h00;
            pal_wr_data_o <= 16'h0000;
        end else begin
            pal_wr_en_o <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (fill_start_i) begin
                        state       <= FILL;
                        fill_cnt    <= 8'h00;
                        fill_val    <= fill_value_i;
                        fill_busy_o <= 1'b1;
                    end else if (pop) begin
                        pal_wr_en_o <= 1'b1;
                        {pal_ben_o, pal_wr_addr_o, pal_wr_data_o} <= fifo_mem[rd_ptr];
                    end
                end
                FILL: begin
                    pal_wr_en_o   <= 1'b1;
                    pal_ben_o     <= 2'b11;
                    pal_wr_addr_o <= fill_cnt;
                    pal_wr_data_o <= fill_val;
                    fill_cnt      <= fill_cnt + 8'd1;
                    if (fill_cnt == 8'hFF) begin
                        state       <= IDLE;
                        fill_busy_o <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    fill_busy_o <= 1'b0;
                end
            endcase
        end
    end

    // Readback: latch request, issue when the port is free, capture the
    // RAM's registered data one cycle later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_pend        <= 1'b0;
            rd_inflight    <= 1'b0;
            rd_addr        <= 8'h00;
            cpu_rd_valid_o <= 1'b0;
            cpu_rd_data_o  <= 16'h0000;
        end else begin
            cpu_rd_valid_o <= 1'b0;
            rd_inflight    <= rd_issue;
            if (rd_inflight) begin
                cpu_rd_data_o  <= pal_rd_data_i;
                cpu_rd_valid_o <= 1'b1;
                rd_pend        <= 1'b0;
            end else if (cpu_rd_req_i && !rd_pend) begin
                rd_pend <= 1'b1;
                rd_addr <= cpu_rd_addr_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_palette_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_palette_ctrl
// Brief    : Directed self-checking bench for palette_ctrl with a palette RAM
//            model (1-cycle registered read, byte-enabled write).
// Revision : 1.0 - initial release
// ============================================================================
module tb_palette_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_req;
    logic        wr_ready;
    logic [7:0]  wr_addr;
    logic [1:0]  wr_ben;
    logic [15:0] wr_data;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_busy;
    logic        fill_start;
    logic [15:0] fill_value;
    logic        fill_busy;
    logic        disp_active;
    logic [7:0]  disp_addr;
    logic        pal_wr_en;
    logic [1:0]  pal_ben;
    logic [7:0]  pal_wr_addr;
    logic [15:0] pal_wr_data;
    logic [7:0]  pal_rd_addr;
    logic [15:0] pal_rd_data = 16'h0000;

    logic [15:0] ram [256] = '{default: 16'h0000};

    int n_cmp = 0;
    int n_bad = 0;
    int busy_cnt;
    int valid_cnt;

    palette_ctrl #(.WR_FIFO_DEPTH(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .cpu_wr_req_i   (wr_req),
        .cpu_wr_ready_o (wr_ready),
        .cpu_wr_addr_i  (wr_addr),
        .cpu_wr_ben_i   (wr_ben),
        .cpu_wr_data_i  (wr_data),
        .cpu_rd_req_i   (rd_req),
        .cpu_rd_addr_i  (rd_addr),
        .cpu_rd_valid_o (rd_valid),
        .cpu_rd_data_o  (rd_data),
        .cpu_rd_busy_o  (rd_busy),
        .fill_start_i   (fill_start),
        .fill_value_i   (fill_value),
        .fill_busy_o    (fill_busy),
        .disp_active_i  (disp_active),
        .disp_addr_i    (disp_addr),
        .pal_wr_en_o    (pal_wr_en),
        .pal_ben_o      (pal_ben),
        .pal_wr_addr_o  (pal_wr_addr),
        .pal_wr_data_o  (pal_wr_data),
        .pal_rd_addr_o  (pal_rd_addr),
        .pal_rd_data_i  (pal_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pal_wr_en) begin
            if (pal_ben[0]) ram[pal_wr_addr][7:0]  <= pal_wr_data[7:0];
            if (pal_ben[1]) ram[pal_wr_addr][15:8] <= pal_wr_data[15:8];
        end
        pal_rd_data <= ram[pal_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input int j);
        wr_addr = 8'(32'h40 + j);
        wr_ben  = 2'b11;
        wr_data = 16'(32'h0100 + j);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},    32'(wr_ready),    32'd1);
        chk({tag, "_wr_en"},    32'(pal_wr_en),   32'd0);
        chk({tag, "_ben"},      32'(pal_ben),     32'd0);
        chk({tag, "_wr_addr"},  32'(pal_wr_addr), 32'd0);
        chk({tag, "_wr_data"},  32'(pal_wr_data), 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_valid),    32'd0);
        chk({tag, "_rd_busy"},  32'(rd_busy),     32'd0);
        chk({tag, "_rd_data"},  32'(rd_data),     32'd0);
        chk({tag, "_fill_busy"},32'(fill_busy),   32'd0);
        chk({tag, "_rd_addr"},  32'(pal_rd_addr), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; wr_req = 1'b0; wr_addr = 8'h00; wr_ben = 2'b00; wr_data = 16'h0000;
        rd_req = 1'b0; rd_addr = 8'h00; fill_start = 1'b0; fill_value = 16'h0000;
        disp_active = 1'b0; disp_addr = 8'h00;

        // Reset values, and display address passthrough during reset
        #12;
        chk_reset_outputs("rst");
        disp_active = 1'b1; disp_addr = 8'h5A; #1;
        chk("rst_disp_rd_addr", 32'(pal_rd_addr), 32'h5A);
        disp_active = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_no_wr", 32'(pal_wr_en), 32'd0);

        // Two queued writes issue on the next two cycles, in order
        wr_req = 1'b1; wr_addr = 8'h03; wr_ben = 2'b11; wr_data = 16'h0AFE;
        tick();
        chk("q_first_not_yet", 32'(pal_wr_en), 32'd0);
        wr_addr = 8'h04; wr_ben = 2'b10; wr_data = 16'h0C4C;
        tick();
        chk("wr_0", 32'({pal_wr_en, pal_ben, pal_wr_addr, pal_wr_data}), 32'({1'b1, 2'b11, 8'h03, 16'h0AFE}));
        wr_req = 1'b0;
        tick();
        chk("wr_1", 32'({pal_wr_en, pal_ben, pal_wr_addr, pal_wr_data}), 32'({1'b1, 2'b10, 8'h04, 16'h0C4C}));
        tick();
        chk("wr_idle", 32'(pal_wr_en), 32'd0);

        // Byte-enable 00 is passed through unchanged
        wr_req = 1'b1; wr_addr = 8'h07; wr_ben = 2'b00; wr_data = 16'h1234;
        tick();
        wr_req = 1'b0;
        tick();
        chk("wr_ben00", 32'({pal_wr_en, pal_ben, pal_wr_addr, pal_wr_data}), 32'({1'b1, 2'b00, 8'h07, 16'h1234}));
        tick();

        // Read-after-write: readback waits for the write to land
        wr_req = 1'b1; wr_addr = 8'h0A; wr_ben = 2'b11; wr_data = 16'h0F77;
        tick();
        wr_req = 1'b0; rd_req = 1'b1; rd_addr = 8'h0A;
        tick();
        rd_req = 1'b0;
        chk("raw_busy", 32'(rd_busy), 32'd1);
        chk("raw_wr_inflight", 32'(pal_wr_en), 32'd1);
        chk("raw_no_issue_yet", 32'(pal_rd_addr), 32'h00);
        tick();
        chk("raw_issue_addr", 32'(pal_rd_addr), 32'h0A);
        tick();
        chk("raw_valid_wait", 32'(rd_valid), 32'd0);
        chk("raw_busy_wait", 32'(rd_busy), 32'd1);
        tick();
        chk("raw_valid", 32'(rd_valid), 32'd1);
        chk("raw_data", 32'(rd_data), 32'h0F77);
        chk("raw_busy_drop", 32'(rd_busy), 32'd0);
        tick();
        chk("raw_valid_pulse", 32'(rd_valid), 32'd0);
        chk("raw_data_hold", 32'(rd_data), 32'h0F77);

        // Display owns the read port; readback completes 2 cycles after it drops
        disp_active = 1'b1; disp_addr = 8'h20; rd_req = 1'b1; rd_addr = 8'h03;
        tick();
        rd_req = 1'b0;
        chk("disp_busy", 32'(rd_busy), 32'd1);
        for (int i = 0; i < 20; i++) begin
            disp_addr = 8'(32'h20 + i);
            #1;
            chk("disp_track", 32'(pal_rd_addr), 32'h20 + 32'(i));
            tick();
        end
        chk("disp_no_valid", 32'(rd_valid), 32'd0);
        disp_active = 1'b0;
        #1;
        chk("disp_issue_addr", 32'(pal_rd_addr), 32'h03);
        tick();
        chk("disp_valid_wait", 32'(rd_valid), 32'd0);
        tick();
        chk("disp_valid", 32'(rd_valid), 32'd1);
        chk("disp_data", 32'(rd_data), 32'h0AFE);
        tick();

        // Fill with 5 back-to-back writes; queue fills at 4, drains after fill
        wr_req = 1'b1; set_entry(0); fill_start = 1'b1; fill_value = 16'h00C5;
        tick();
        fill_start = 1'b0;
        chk("fill_busy_on", 32'(fill_busy), 32'd1);
        busy_cnt = int'(fill_busy);
        set_entry(1);
        for (int i = 0; i < 256; i++) begin
            tick();
            chk("fill_wr", 32'({pal_wr_en, pal_ben, pal_wr_addr, pal_wr_data}), 32'({1'b1, 2'b11, 8'(i), 16'h00C5}));
            busy_cnt += int'(fill_busy);
            if (i == 0) set_entry(2);
            else if (i == 1) set_entry(3);
            else if (i == 2) begin
                chk("fill_ready_full", 32'(wr_ready), 32'd0);
                set_entry(4);
            end
        end
        chk("fill_busy_cycles", 32'(busy_cnt), 32'd256);
        chk("fill_busy_off", 32'(fill_busy), 32'd0);
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("drain_wr", 32'({pal_wr_en, pal_ben, pal_wr_addr, pal_wr_data}),
                32'({1'b1, 2'b11, 8'(32'h40 + j), 16'(32'h0100 + j)}));
            if (j == 0) chk("drain_ready", 32'(wr_ready), 32'd1);
            if (j == 1) wr_req = 1'b0;
        end
        tick();
        chk("drain_done", 32'(pal_wr_en), 32'd0);

        // Second fill_start and second read request while busy are ignored
        fill_start = 1'b1; fill_value = 16'hBEEF; rd_req = 1'b1; rd_addr = 8'h40;
        tick();
        fill_start = 1'b0; rd_req = 1'b0;
        chk("f2_rd_busy", 32'(rd_busy), 32'd1);
        valid_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            valid_cnt += int'(rd_valid);
            if (i == 49) begin
                chk("f2_at_cnt50", 32'(pal_wr_addr), 32'd49);
                fill_start = 1'b1; fill_value = 16'h1111; rd_req = 1'b1; rd_addr = 8'h41;
            end else if (i == 50) begin
                fill_start = 1'b0; rd_req = 1'b0;
            end
            if (i == 255)
                chk("f2_last_wr", 32'({pal_wr_en, pal_ben, pal_wr_addr, pal_wr_data}), 32'({1'b1, 2'b11, 8'hFF, 16'hBEEF}));
        end
        chk("f2_busy_off", 32'(fill_busy), 32'd0);
        tick();
        valid_cnt += int'(rd_valid);
        chk("f2_issue_addr", 32'(pal_rd_addr), 32'h40);
        for (int k = 0; k < 10; k++) begin
            tick();
            valid_cnt += int'(rd_valid);
        end
        chk("f2_valid_count", 32'(valid_cnt), 32'd1);
        chk("f2_rd_data", 32'(rd_data), 32'hBEEF);
        chk("f2_no_refill", 32'(fill_busy), 32'd0);

        // Reset at fill counter 100 with 2 writes queued and a read pending
        fill_start = 1'b1; fill_value = 16'h5555; rd_req = 1'b1; rd_addr = 8'h22;
        tick();
        fill_start = 1'b0; rd_req = 1'b0; wr_req = 1'b1; set_entry(0);
        tick();
        set_entry(1);
        tick();
        wr_req = 1'b0;
        for (int i = 0; i < 98; i++) tick();
        chk("pre_rst_wr_addr", 32'(pal_wr_addr), 32'd99);
        chk("pre_rst_fill_busy", 32'(fill_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("post_rst_idle_wr", 32'(pal_wr_en), 32'd0);
        end
        chk("post_rst_rd_busy", 32'(rd_busy), 32'd0);
        chk("post_rst_fill_busy", 32'(fill_busy), 32'd0);
        chk("post_rst_valid", 32'(rd_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
